// File: rtl/line_memory_responder_if.sv
// rtl/line_memory_responder_if.sv - dcache line request/response bundle
// Purpose: groups the dcache line-fill/write-back request and response signals.
// Signals:
//   addr_i, data_i, enable_i, write_i        request (initiator -> responder)
//   ack_o, data_o                            completion pulse and read line
//   busy_o, err_o, rd_count_o, wr_count_o    status and statistics
interface line_memory_responder_if;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic         enable_i;
  logic         write_i;
  logic         ack_o;
  logic [255:0] data_o;
  logic         busy_o;
  logic         err_o;
  logic [15:0]  rd_count_o;
  logic [15:0]  wr_count_o;

  modport master (
    output addr_i, data_i, enable_i, write_i,
    input  ack_o, data_o, busy_o, err_o, rd_count_o, wr_count_o
  );

  modport slave (
    input  addr_i, data_i, enable_i, write_i,
    output ack_o, data_o, busy_o, err_o, rd_count_o, wr_count_o
  );
endinterface

// File: rtl/line_memory_responder.sv
// rtl/line_memory_responder.sv - fixed-latency 256-bit line memory responder
// Purpose: accepts one line read/write at a time, services it against the
//   internal line array after LATENCY cycles and returns a one-cycle ack.
// Ports:
//   clk_i   clock, rising edge
//   rst_i   asynchronous active-low reset
//   bus     slave side of line_memory_responder_if (request, ack, read data,
//           busy, sticky range error, saturating read/write counters)
module line_memory_responder #(
  parameter int unsigned LATENCY    = 10,
  parameter int unsigned DEPTH_LOG2 = 9
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  line_memory_responder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  // The countdown is loaded at acceptance and the FSM leaves WAIT on the edge
  // that sees it at zero, so ACK is entered exactly LATENCY edges after E0.
  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  state_t                  state_q, state_d;
  logic [7:0]              cnt_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic                    wr_q;
  logic                    oor_q;
  logic [255:0]            wdata_q;
  logic [255:0]            data_q;
  logic                    err_q;
  logic [15:0]             rd_cnt_q;
  logic [15:0]             wr_cnt_q;
  logic                    enter_ack;

  // Line array; intentionally not reset so contents survive rst_i.
  logic [255:0] memory [0:(2**DEPTH_LOG2)-1];

  always_comb begin
    state_d   = state_q;
    enter_ack = 1'b0;
    case (state_q)
      IDLE: if (bus.enable_i) state_d = WAIT;
      WAIT: begin
        if (cnt_q == 8'd0) begin
          state_d   = ACK;
          enter_ack = 1'b1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      idx_q    <= '0;
      wr_q     <= 1'b0;
      oor_q    <= 1'b0;
      wdata_q  <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.enable_i) begin
            idx_q   <= bus.addr_i[DEPTH_LOG2+4:5];
            wr_q    <= bus.write_i;
            wdata_q <= bus.data_i;
            oor_q   <= |bus.addr_i[31:DEPTH_LOG2+5];
            cnt_q   <= LAT_M1;
          end
        end
        WAIT: begin
          if (cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;
        end
        ACK: begin
          if (wr_q) begin
            if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
          end else begin
            if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
          end
        end
        default: ;
      endcase

      if (enter_ack) begin
        if (!wr_q) data_q <= oor_q ? '0 : memory[idx_q];
        if (oor_q) err_q <= 1'b1;
      end
    end
  end

  // enter_ack is only possible from WAIT, which reset forces away from, so a
  // write interrupted by reset never reaches the array.
  always_ff @(posedge clk_i) begin
    if (enter_ack && wr_q && !oor_q) memory[idx_q] <= wdata_q;
  end

  assign bus.ack_o      = (state_q == ACK);
  assign bus.busy_o     = (state_q != IDLE);
  assign bus.data_o     = data_q;
  assign bus.err_o      = err_q;
  assign bus.rd_count_o = rd_cnt_q;
  assign bus.wr_count_o = wr_cnt_q;

endmodule

// File: tb/tb_line_memory_responder.sv
// tb/tb_line_memory_responder.sv - directed bench for line_memory_responder
module tb_line_memory_responder;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   nvec  = 0;
  int   nfail = 0;

  always #5 clk_i = ~clk_i;

  line_memory_responder_if if0 ();
  line_memory_responder_if if1 ();

  line_memory_responder #(.LATENCY(10), .DEPTH_LOG2(9)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (if0)
  );

  line_memory_responder #(.LATENCY(1), .DEPTH_LOG2(9)) dut1 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (if1)
  );

  // Issue one request on if0 (LATENCY 10), holding enable until ack is seen.
  // k counts edges after acceptance; optionally disturbs inputs mid-WAIT.
  task automatic run_req(input logic [31:0] a, input logic [255:0] d, input logic w,
                         input logic disturb,
                         output int ack_k, output int acks, output int busy_n);
    @(negedge clk_i);
    if0.addr_i = a; if0.data_i = d; if0.write_i = w; if0.enable_i = 1'b1;
    @(posedge clk_i); #1;
    busy_n = if0.busy_o ? 1 : 0;
    acks = 0; ack_k = -1;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk_i); #1;
      if (disturb && k == 3) begin
        if0.addr_i = 32'h0; if0.data_i = ~d; if0.write_i = ~w;
      end
      if (if0.busy_o) busy_n++;
      if (if0.ack_o) begin
        acks++;
        if (ack_k < 0) ack_k = k;
        if0.enable_i = 1'b0;
      end
    end
    if0.enable_i = 1'b0;
  endtask

  task automatic test_reset();
    nvec++; if (if0.ack_o !== 1'b0) begin nfail++; $display("FAIL reset_ack got %b expected 0", if0.ack_o); end
    nvec++; if (if0.busy_o !== 1'b0) begin nfail++; $display("FAIL reset_busy got %b expected 0", if0.busy_o); end
    nvec++; if (if0.err_o !== 1'b0) begin nfail++; $display("FAIL reset_err got %b expected 0", if0.err_o); end
    nvec++; if (if0.data_o !== 256'h0) begin nfail++; $display("FAIL reset_data got %h expected 0", if0.data_o); end
    nvec++; if (if0.rd_count_o !== 16'h0 || if0.wr_count_o !== 16'h0) begin
      nfail++; $display("FAIL reset_counts got %h/%h expected 0/0", if0.rd_count_o, if0.wr_count_o);
    end
    @(negedge clk_i); rst_i = 1'b1;
  endtask

  task automatic test_read();
    int ack_k, acks, busy_n;
    dut.memory[0] = 256'h5;
    run_req(32'h0, 256'h0, 1'b0, 1'b0, ack_k, acks, busy_n);
    nvec++; if (ack_k !== 10) begin nfail++; $display("FAIL read_ack_cycle got %0d expected 10", ack_k); end
    nvec++; if (acks !== 1) begin nfail++; $display("FAIL read_ack_count got %0d expected 1", acks); end
    nvec++; if (busy_n !== 11) begin nfail++; $display("FAIL read_busy_cycles got %0d expected 11", busy_n); end
    nvec++; if (if0.data_o !== 256'h5) begin nfail++; $display("FAIL read_data got %h expected 5", if0.data_o); end
    nvec++; if (if0.rd_count_o !== 16'd1) begin nfail++; $display("FAIL read_rd_count got %0d expected 1", if0.rd_count_o); end
  endtask

  task automatic test_write_read();
    int ack_k, acks, busy_n;
    run_req(32'h0000_0420, {8{32'hDEADBEEF}}, 1'b1, 1'b0, ack_k, acks, busy_n);
    nvec++; if (ack_k !== 10) begin nfail++; $display("FAIL write_ack_cycle got %0d expected 10", ack_k); end
    nvec++; if (dut.memory[33] !== {8{32'hDEADBEEF}}) begin nfail++; $display("FAIL write_mem33 got %h expected deadbeef x8", dut.memory[33]); end
    nvec++; if (if0.data_o !== 256'h5) begin nfail++; $display("FAIL write_data_hold got %h expected 5", if0.data_o); end
    run_req(32'h0000_0420, 256'h0, 1'b0, 1'b0, ack_k, acks, busy_n);
    nvec++; if (if0.data_o !== {8{32'hDEADBEEF}}) begin nfail++; $display("FAIL wr_rd_data got %h expected deadbeef x8", if0.data_o); end
    nvec++; if (if0.wr_count_o !== 16'd1 || if0.rd_count_o !== 16'd2) begin
      nfail++; $display("FAIL wr_rd_counts got wr %0d rd %0d expected wr 1 rd 2", if0.wr_count_o, if0.rd_count_o);
    end
  endtask

  task automatic test_offset_latch();
    int ack_k, acks, busy_n;
    run_req(32'h45, {8{32'h12345678}}, 1'b1, 1'b1, ack_k, acks, busy_n);
    nvec++; if (acks !== 1) begin nfail++; $display("FAIL latch_ack_count got %0d expected 1", acks); end
    nvec++; if (dut.memory[2] !== {8{32'h12345678}}) begin nfail++; $display("FAIL latch_mem2 got %h expected 12345678 x8", dut.memory[2]); end
    nvec++; if (dut.memory[0] !== 256'h5) begin nfail++; $display("FAIL latch_mem0 got %h expected 5", dut.memory[0]); end
    nvec++; if (if0.wr_count_o !== 16'd2) begin nfail++; $display("FAIL latch_wr_count got %0d expected 2", if0.wr_count_o); end
  endtask

  task automatic test_out_of_range();
    int ack_k, acks, busy_n;
    run_req(32'h0000_4000, 256'h0, 1'b0, 1'b0, ack_k, acks, busy_n);
    nvec++; if (ack_k !== 10) begin nfail++; $display("FAIL oor_ack_cycle got %0d expected 10", ack_k); end
    nvec++; if (if0.data_o !== 256'h0) begin nfail++; $display("FAIL oor_read_data got %h expected 0", if0.data_o); end
    nvec++; if (if0.err_o !== 1'b1) begin nfail++; $display("FAIL oor_err got %b expected 1", if0.err_o); end
    run_req(32'h0000_4000, {8{32'hFFFFFFFF}}, 1'b1, 1'b0, ack_k, acks, busy_n);
    nvec++; if (dut.memory[0] !== 256'h5) begin nfail++; $display("FAIL oor_write_mem0 got %h expected 5", dut.memory[0]); end
    nvec++; if (if0.err_o !== 1'b1) begin nfail++; $display("FAIL oor_err_sticky got %b expected 1", if0.err_o); end
    nvec++; if (if0.wr_count_o !== 16'd3 || if0.rd_count_o !== 16'd3) begin
      nfail++; $display("FAIL oor_counts got wr %0d rd %0d expected wr 3 rd 3", if0.wr_count_o, if0.rd_count_o);
    end
  endtask

  task automatic test_reset_mid();
    int ack_k, acks, busy_n;
    dut.memory[5] = {8{32'h0BADF00D}};
    @(negedge clk_i);
    if0.addr_i = 32'hA0; if0.data_i = {8{32'h11111111}}; if0.write_i = 1'b1; if0.enable_i = 1'b1;
    @(posedge clk_i);
    repeat (4) @(posedge clk_i);
    #1 rst_i = 1'b0;
    #1;
    nvec++; if (if0.busy_o !== 1'b0 || if0.ack_o !== 1'b0) begin
      nfail++; $display("FAIL rstmid_busy_ack got %b/%b expected 0/0", if0.busy_o, if0.ack_o);
    end
    nvec++; if (if0.err_o !== 1'b0 || if0.data_o !== 256'h0) begin
      nfail++; $display("FAIL rstmid_err_data got %b/%h expected 0/0", if0.err_o, if0.data_o);
    end
    nvec++; if (if0.rd_count_o !== 16'h0 || if0.wr_count_o !== 16'h0) begin
      nfail++; $display("FAIL rstmid_counts got %h/%h expected 0/0", if0.rd_count_o, if0.wr_count_o);
    end
    acks = 0;
    repeat (12) begin @(posedge clk_i); #1; if (if0.ack_o) acks++; end
    nvec++; if (acks !== 0) begin nfail++; $display("FAIL rstmid_no_ack got %0d expected 0", acks); end
    @(negedge clk_i); if0.enable_i = 1'b0; rst_i = 1'b1;
    nvec++; if (dut.memory[5] !== {8{32'h0BADF00D}}) begin nfail++; $display("FAIL rstmid_mem5 got %h expected 0badf00d x8", dut.memory[5]); end
    run_req(32'hA0, 256'h0, 1'b0, 1'b0, ack_k, acks, busy_n);
    nvec++; if (ack_k !== 10) begin nfail++; $display("FAIL rstmid_fresh_ack got %0d expected 10", ack_k); end
    nvec++; if (if0.data_o !== {8{32'h0BADF00D}}) begin nfail++; $display("FAIL rstmid_fresh_data got %h expected 0badf00d x8", if0.data_o); end
    nvec++; if (if0.rd_count_o !== 16'd1) begin nfail++; $display("FAIL rstmid_fresh_rd got %0d expected 1", if0.rd_count_o); end
  endtask

  // LATENCY 1, enable held through two requests: acks one edge after each
  // acceptance and LATENCY+2 edges apart; read counter saturates.
  task automatic test_latency1_back_to_back();
    int acks, first_k, second_k;
    @(negedge clk_i);
    dut1.memory[7] = {8{32'hCAFEF00D}};
    dut1.rd_cnt_q  = 16'hFFFE;
    if1.addr_i = 32'hE0; if1.data_i = 256'h0; if1.write_i = 1'b0; if1.enable_i = 1'b1;
    @(posedge clk_i); #1;
    acks = 0; first_k = -1; second_k = -1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk_i); #1;
      if (if1.ack_o) begin
        acks++;
        if (acks == 1) first_k = k;
        if (acks == 2) begin second_k = k; if1.enable_i = 1'b0; end
      end
    end
    if1.enable_i = 1'b0;
    nvec++; if (first_k !== 1) begin nfail++; $display("FAIL lat1_first_ack got %0d expected 1", first_k); end
    nvec++; if (second_k !== 4) begin nfail++; $display("FAIL lat1_b2b_ack got %0d expected 4", second_k); end
    nvec++; if (acks !== 2) begin nfail++; $display("FAIL lat1_ack_count got %0d expected 2", acks); end
    nvec++; if (if1.data_o !== {8{32'hCAFEF00D}}) begin nfail++; $display("FAIL lat1_data got %h expected cafef00d x8", if1.data_o); end
    nvec++; if (if1.rd_count_o !== 16'hFFFF) begin nfail++; $display("FAIL lat1_rd_saturate got %h expected ffff", if1.rd_count_o); end
  endtask

  initial begin
    if0.addr_i = '0; if0.data_i = '0; if0.enable_i = 1'b0; if0.write_i = 1'b0;
    if1.addr_i = '0; if1.data_i = '0; if1.enable_i = 1'b0; if1.write_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    test_reset();
    test_read();
    test_write_read();
    test_offset_latch();
    test_out_of_range();
    test_reset_mid();
    test_latency1_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
